pipeline_stall_ctrl: RTL

//  Sequences the 5-stage pipeline registers and shares the data memory port.

---
 rtl/pipeline_stall_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: runs multi-cycle data-memory accesses for the
// MEM-stage instruction, freezes the pipeline while they run, and inserts a
// single ID/EX bubble on load-use hazards.
module pipeline_stall_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mem_memread_i,
  input  logic              mem_memwrite_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  input  logic              ex_memread_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              idex_flush_o,
  output logic              pipe_en_o,
  output logic [31:0]       stall_cycles_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // Counter value on the last ACCESS cycle allowed before forced completion.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         stall_q, stall_d;

  logic mem_op;
  logic mem_stall;
  logic load_use;

  assign mem_op    = mem_memread_i | mem_memwrite_i;
  assign mem_stall = ((state_q == StIdle) && mem_op) || (state_q == StAccess);
  assign load_use  = ex_memread_i && (ex_rd_i != 5'd0) &&
                     ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // Next-state and datapath latching for the memory access sequencer.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && mem_op) begin
          state_d = StAccess;
          req_d   = 1'b1;
          we_d    = mem_memwrite_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack wins over a timeout landing on the same edge.
        if (dmem_ack_i) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) rdata_d = dmem_rdata_i;
        end else if (cnt_q >= TimeoutLast) begin
          state_d   = StDone;
          req_d     = 1'b0;
          timeout_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end
      end
      StDone: begin
        if (start_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // Saturating count of cycles the pipeline is held for memory.
  always_comb begin
    stall_d = stall_q;
    if (start_i && mem_stall && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  // Pipeline enables; memory stall outranks the hazard so the bubble lands
  // only once the access has completed.
  always_comb begin
    pc_en_o      = 1'b0;
    ifid_en_o    = 1'b0;
    pipe_en_o    = 1'b0;
    idex_flush_o = 1'b0;
    if (!start_i || mem_stall) begin
      pc_en_o = 1'b0;
    end else if (load_use) begin
      pipe_en_o    = 1'b1;
      idex_flush_o = 1'b1;
    end else begin
      pc_en_o   = 1'b1;
      ifid_en_o = 1'b1;
      pipe_en_o = 1'b1;
    end
  end

  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_wdata_o   = wdata_q;
  assign mem_rdata_o    = rdata_q;
  assign stall_cycles_o = stall_q;
  assign timeout_o      = timeout_q;

endmodule
